// File: rtl/syn_branch_predictor.sv
// Fully-associative branch target buffer with saturating direction counters,
// round-robin or true-LRU replacement, and saturating event statistics.
module syn_branch_predictor #(
    parameter int AddrBits = 10,
    parameter int Entries  = 8,
    parameter int CntBits  = 2,
    parameter int ReplMode = 0,
    parameter int StatBits = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                en,
    input  logic                flush,
    input  logic                lk_valid,
    input  logic [AddrBits-1:0] lk_pc,
    output logic                lk_hit,
    output logic                lk_taken,
    output logic [AddrBits-1:0] lk_next_pc,
    input  logic                upd_en,
    input  logic [AddrBits-1:0] upd_pc,
    input  logic                upd_taken,
    input  logic [AddrBits-1:0] upd_target,
    input  logic                upd_mispred,
    input  logic                stat_clr,
    output logic [StatBits-1:0] stat_lookups,
    output logic [StatBits-1:0] stat_hits,
    output logic [StatBits-1:0] stat_mispred
);
    localparam int IW = $clog2(Entries);
    localparam logic [CntBits-1:0] CNT_MAX  = '1;
    localparam logic [CntBits-1:0] CNT_WEAK = CntBits'(1) << (CntBits - 1);
    localparam logic [IW-1:0]      AGE_OLD  = IW'(Entries - 1);

    logic [Entries-1:0]                valid_q;
    logic [Entries-1:0][AddrBits-1:0]  tag_q;
    logic [Entries-1:0][AddrBits-1:0]  tgt_q;
    logic [Entries-1:0][CntBits-1:0]   cnt_q;
    logic [Entries-1:0][IW-1:0]        age_q;
    logic [IW-1:0]                     rr_q;

    logic [Entries-1:0] lk_match, upd_match, old_vec;

    // Per-entry tag compare for both ports and the LRU-oldest flag
    for (genvar g = 0; g < Entries; g++) begin : g_ent
        assign lk_match[g]  = valid_q[g] && (tag_q[g] == lk_pc);
        assign upd_match[g] = valid_q[g] && (tag_q[g] == upd_pc);
        assign old_vec[g]   = (age_q[g] == AGE_OLD);
    end

    logic [IW-1:0] lk_idx, upd_idx, free_idx, old_idx, victim, touch_idx;
    logic          upd_hit, has_free;

    // Encode hit positions; descending scan makes the lowest free index win
    always_comb begin
        lk_idx   = '0;
        upd_idx  = '0;
        free_idx = '0;
        old_idx  = '0;
        lk_hit   = 1'b0;
        upd_hit  = 1'b0;
        has_free = 1'b0;
        for (int i = Entries - 1; i >= 0; i--) begin
            if (lk_match[i])  begin lk_hit  = 1'b1; lk_idx  = IW'(i); end
            if (upd_match[i]) begin upd_hit = 1'b1; upd_idx = IW'(i); end
            if (!valid_q[i])  begin has_free = 1'b1; free_idx = IW'(i); end
            if (old_vec[i])   old_idx = IW'(i);
        end
    end

    assign lk_taken   = lk_hit && cnt_q[lk_idx][CntBits-1];
    assign lk_next_pc = lk_taken ? tgt_q[lk_idx] : lk_pc + AddrBits'(1);

    logic upd_ok, alloc, touch, rr_adv;
    assign victim    = has_free ? free_idx : ((ReplMode == 1) ? old_idx : rr_q);
    assign upd_ok    = en && upd_en && !flush;
    assign alloc     = upd_ok && !upd_hit && upd_taken;
    assign touch     = upd_ok && (upd_hit || upd_taken);
    assign touch_idx = upd_hit ? upd_idx : victim;
    assign rr_adv    = alloc && !has_free && (ReplMode == 0);

    // Table state: counters, targets, allocation, replacement pointer, ages
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
            tag_q   <= '0;
            tgt_q   <= '0;
            cnt_q   <= '0;
            rr_q    <= '0;
            for (int i = 0; i < Entries; i++) age_q[i] <= IW'(i);
        end else if (en) begin
            if (flush) begin
                valid_q <= '0;
                rr_q    <= '0;
                for (int i = 0; i < Entries; i++) age_q[i] <= IW'(i);
            end else begin
                if (upd_ok && upd_hit) begin
                    if (upd_taken) begin
                        if (cnt_q[upd_idx] != CNT_MAX) cnt_q[upd_idx] <= cnt_q[upd_idx] + CntBits'(1);
                        tgt_q[upd_idx] <= upd_target;
                    end else if (cnt_q[upd_idx] != '0) begin
                        cnt_q[upd_idx] <= cnt_q[upd_idx] - CntBits'(1);
                    end
                end
                if (alloc) begin
                    valid_q[victim] <= 1'b1;
                    tag_q[victim]   <= upd_pc;
                    tgt_q[victim]   <= upd_target;
                    cnt_q[victim]   <= CNT_WEAK;
                end
                if (rr_adv) rr_q <= rr_q + IW'(1);
                // Touched entry becomes youngest; younger ones age by one
                if (touch) begin
                    for (int i = 0; i < Entries; i++) begin
                        if (IW'(i) == touch_idx)            age_q[i] <= '0;
                        else if (age_q[i] < age_q[touch_idx]) age_q[i] <= age_q[i] + IW'(1);
                    end
                end
            end
        end
    end

    function automatic logic [StatBits-1:0] sat_inc(input logic [StatBits-1:0] v, input logic inc);
        return (inc && (v != '1)) ? v + StatBits'(1) : v;
    endfunction

    // Saturating statistics; clear wins over same-cycle increments
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_lookups <= '0;
            stat_hits    <= '0;
            stat_mispred <= '0;
        end else if (en) begin
            if (stat_clr) begin
                stat_lookups <= '0;
                stat_hits    <= '0;
                stat_mispred <= '0;
            end else begin
                stat_lookups <= sat_inc(stat_lookups, lk_valid);
                stat_hits    <= sat_inc(stat_hits, lk_valid && lk_hit);
                stat_mispred <= sat_inc(stat_mispred, upd_en && upd_mispred);
            end
        end
    end
endmodule

// File: tb/tb_syn_branch_predictor.sv
// Bench: three predictor instances (round-robin, LRU, 4-bit stats) on shared
// stimulus, checked against constant vectors and an MRU-list reference model.
module tb_syn_branch_predictor;
    logic clk = 1'b0;
    logic rst_n, en, flush, lk_valid, upd_en, upd_taken, upd_mispred, stat_clr;
    logic [9:0] lk_pc, upd_pc, upd_target;

    logic [2:0]       hit_o, tk_o;
    logic [9:0]       npc0, npc1, npc2;
    logic [31:0]      sl0, sh0, sm0, sl1, sh1, sm1;
    logic [3:0]       sl2, sh2, sm2;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    syn_branch_predictor #(.ReplMode(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .en(en), .flush(flush), .lk_valid(lk_valid), .lk_pc(lk_pc),
        .lk_hit(hit_o[0]), .lk_taken(tk_o[0]), .lk_next_pc(npc0), .upd_en(upd_en), .upd_pc(upd_pc),
        .upd_taken(upd_taken), .upd_target(upd_target), .upd_mispred(upd_mispred), .stat_clr(stat_clr),
        .stat_lookups(sl0), .stat_hits(sh0), .stat_mispred(sm0));
    syn_branch_predictor #(.ReplMode(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .en(en), .flush(flush), .lk_valid(lk_valid), .lk_pc(lk_pc),
        .lk_hit(hit_o[1]), .lk_taken(tk_o[1]), .lk_next_pc(npc1), .upd_en(upd_en), .upd_pc(upd_pc),
        .upd_taken(upd_taken), .upd_target(upd_target), .upd_mispred(upd_mispred), .stat_clr(stat_clr),
        .stat_lookups(sl1), .stat_hits(sh1), .stat_mispred(sm1));
    syn_branch_predictor #(.ReplMode(0), .StatBits(4)) dut2 (
        .clk(clk), .rst_n(rst_n), .en(en), .flush(flush), .lk_valid(lk_valid), .lk_pc(lk_pc),
        .lk_hit(hit_o[2]), .lk_taken(tk_o[2]), .lk_next_pc(npc2), .upd_en(upd_en), .upd_pc(upd_pc),
        .upd_taken(upd_taken), .upd_target(upd_target), .upd_mispred(upd_mispred), .stat_clr(stat_clr),
        .stat_lookups(sl2), .stat_hits(sh2), .stat_mispred(sm2));

    // ---------------- reference model ----------------
    // Each instance: entry list, MRU-first ordering list, round-robin pointer, stats
    bit         mv[3][8];
    logic [9:0] mtag[3][8];
    logic [9:0] mtgt[3][8];
    int         mcnt[3][8];
    int         ord[3][8];
    int         mrr[3];
    longint     ms_l[3], ms_h[3], ms_m[3];

    task automatic chk(input string nm, input longint act, input longint exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h), want %0d (0x%0h) at %0t", nm, act, act, exp, exp, $time);
        end
    endtask

    function automatic int mfind(input int d, input logic [9:0] pc);
        for (int i = 0; i < 8; i++) if (mv[d][i] && mtag[d][i] == pc) return i;
        return -1;
    endfunction

    task automatic mtouch(input int d, input int k);
        int p = 0;
        for (int i = 0; i < 8; i++) if (ord[d][i] == k) p = i;
        for (int j = p; j > 0; j--) ord[d][j] = ord[d][j-1];
        ord[d][0] = k;
    endtask

    task automatic mreset();
        for (int d = 0; d < 3; d++) begin
            for (int i = 0; i < 8; i++) begin mv[d][i] = 0; mcnt[d][i] = 0; ord[d][i] = i; end
            mrr[d] = 0; ms_l[d] = 0; ms_h[d] = 0; ms_m[d] = 0;
        end
    endtask

    function automatic longint sat(input int d, input longint v, input bit inc);
        longint mx = (d == 2) ? 64'd15 : 64'hFFFF_FFFF;
        return (inc && v < mx) ? v + 1 : v;
    endfunction

    // Apply one clock edge of the specified rules to the model
    task automatic mcommit();
        if (!en) return;
        for (int d = 0; d < 3; d++) begin
            int h = mfind(d, lk_pc);
            if (stat_clr) begin ms_l[d] = 0; ms_h[d] = 0; ms_m[d] = 0; end
            else begin
                ms_l[d] = sat(d, ms_l[d], lk_valid);
                ms_h[d] = sat(d, ms_h[d], lk_valid && h >= 0);
                ms_m[d] = sat(d, ms_m[d], upd_en && upd_mispred);
            end
            if (flush) begin
                for (int i = 0; i < 8; i++) begin mv[d][i] = 0; ord[d][i] = i; end
                mrr[d] = 0;
            end else if (upd_en) begin
                int u = mfind(d, upd_pc);
                if (u >= 0) begin
                    if (upd_taken) begin
                        if (mcnt[d][u] < 3) mcnt[d][u]++;
                        mtgt[d][u] = upd_target;
                    end else if (mcnt[d][u] > 0) mcnt[d][u]--;
                    mtouch(d, u);
                end else if (upd_taken) begin
                    int v = -1;
                    for (int i = 7; i >= 0; i--) if (!mv[d][i]) v = i;
                    if (v < 0) begin
                        if (d == 1) v = ord[d][7];
                        else begin v = mrr[d]; mrr[d] = (mrr[d] + 1) % 8; end
                    end
                    mv[d][v] = 1; mtag[d][v] = upd_pc; mtgt[d][v] = upd_target; mcnt[d][v] = 2;
                    mtouch(d, v);
                end
            end
        end
    endtask

    task automatic mcheck_lookup();
        logic [9:0] npc_a [3];
        npc_a[0] = npc0; npc_a[1] = npc1; npc_a[2] = npc2;
        for (int d = 0; d < 3; d++) begin
            int h = mfind(d, lk_pc);
            bit et = (h >= 0) && (mcnt[d][h] >= 2);
            logic [9:0] en_pc = et ? mtgt[d][h] : lk_pc + 10'd1;
            chk($sformatf("model_hit%0d", d), hit_o[d], h >= 0);
            chk($sformatf("model_taken%0d", d), tk_o[d], et);
            chk($sformatf("model_npc%0d", d), npc_a[d], en_pc);
        end
    endtask

    task automatic mcheck_stats();
        chk("stat_l0", sl0, ms_l[0]); chk("stat_h0", sh0, ms_h[0]); chk("stat_m0", sm0, ms_m[0]);
        chk("stat_l1", sl1, ms_l[1]); chk("stat_h1", sh1, ms_h[1]); chk("stat_m1", sm1, ms_m[1]);
        chk("stat_l2", {28'd0, sl2}, ms_l[2]); chk("stat_h2", {28'd0, sh2}, ms_h[2]);
        chk("stat_m2", {28'd0, sm2}, ms_m[2]);
    endtask

    // One cycle: check combinational outputs, clock, advance model, check stats
    task automatic step();
        #1 mcheck_lookup();
        @(posedge clk);
        mcommit();
        #1 mcheck_stats();
    endtask

    task automatic idle();
        flush = 0; lk_valid = 0; upd_en = 0; upd_taken = 0; upd_mispred = 0; stat_clr = 0; en = 1;
    endtask

    task automatic upd(input logic [9:0] pc, input bit tk, input logic [9:0] tg);
        idle(); upd_en = 1; upd_pc = pc; upd_taken = tk; upd_target = tg; step();
    endtask

    typedef struct {
        logic [9:0] pc;
        bit         ue;
        logic [9:0] upc;
        bit         utk;
        logic [9:0] utg;
        bit         e_hit;
        bit         e_tk;
        logic [9:0] e_npc;
    } vec_t;
    vec_t vecs[9];

    initial begin
        vecs[0] = '{10'h010, 0, 10'h000, 0, 10'h000, 0, 0, 10'h011};
        vecs[1] = '{10'h3FF, 0, 10'h000, 0, 10'h000, 0, 0, 10'h000};
        vecs[2] = '{10'h020, 1, 10'h020, 1, 10'h080, 0, 0, 10'h021};
        vecs[3] = '{10'h020, 1, 10'h020, 0, 10'h000, 1, 1, 10'h080};
        vecs[4] = '{10'h020, 1, 10'h020, 0, 10'h000, 1, 0, 10'h021};
        vecs[5] = '{10'h020, 1, 10'h020, 0, 10'h000, 1, 0, 10'h021};
        vecs[6] = '{10'h020, 0, 10'h000, 0, 10'h000, 1, 0, 10'h021};
        vecs[7] = '{10'h030, 1, 10'h030, 1, 10'h0C0, 0, 0, 10'h031};
        vecs[8] = '{10'h030, 0, 10'h000, 0, 10'h000, 1, 1, 10'h0C0};

        rst_n = 0; lk_pc = 0; upd_pc = 0; upd_target = 0; idle();
        mreset();
        #12 rst_n = 1;
        chk("rst_stat_lookups", sl0, 0);
        chk("rst_stat_hits", sh1, 0);

        // Directed table: lookup, same-cycle update, saturation, wrap
        foreach (vecs[k]) begin
            idle(); lk_valid = 1; lk_pc = vecs[k].pc;
            upd_en = vecs[k].ue; upd_pc = vecs[k].upc; upd_taken = vecs[k].utk; upd_target = vecs[k].utg;
            #1;
            for (int d = 0; d < 3; d++) begin
                chk($sformatf("vec%0d_hit%0d", k, d), hit_o[d], vecs[k].e_hit);
                chk($sformatf("vec%0d_taken%0d", k, d), tk_o[d], vecs[k].e_tk);
            end
            chk($sformatf("vec%0d_npc", k), npc0, vecs[k].e_npc);
            step();
        end

        // Replacement: fill, touch 0x100, then overflow
        idle(); flush = 1; step();
        for (int i = 0; i < 8; i++) upd(10'h100 + 10'(i), 1, 10'h200 + 10'(i));
        upd(10'h100, 1, 10'h250);
        upd(10'h108, 1, 10'h208);
        idle(); lk_pc = 10'h100; #1;
        chk("rr_evict_100", hit_o[0], 0);
        chk("lru_keep_100", hit_o[1], 1);
        chk("lru_npc_100", npc1, 10'h250);
        step();
        lk_pc = 10'h101; #1;
        chk("rr_keep_101", hit_o[0], 1);
        chk("lru_evict_101", hit_o[1], 0);
        step();
        upd(10'h109, 1, 10'h209);
        idle(); lk_pc = 10'h101; #1;
        chk("rr_evict_101", hit_o[0], 0);
        step();
        lk_pc = 10'h102; #1;
        chk("rr_keep_102", hit_o[0], 1);
        step();

        // Statistics
        idle(); stat_clr = 1; step();
        for (int i = 0; i < 5; i++) begin
            idle(); lk_valid = 1; lk_pc = (i < 3) ? 10'h103 + 10'(i) : 10'h3AA;
            if (i >= 3) begin upd_en = 1; upd_pc = 10'h3F0; upd_mispred = 1; end
            step();
        end
        chk("stats_lookups", sl0, 5); chk("stats_hits", sh0, 3); chk("stats_mispred", sm0, 2);
        idle(); stat_clr = 1; lk_valid = 1; lk_pc = 10'h103; step();
        chk("clr_lookups", sl0, 0); chk("clr_hits", sh0, 0); chk("clr_mispred", sm0, 0);
        for (int i = 0; i < 20; i++) begin idle(); lk_valid = 1; lk_pc = 10'h3AA; step(); end
        chk("sat4_lookups", {28'd0, sl2}, 15);
        chk("wide_lookups", sl0, 20);
        idle(); flush = 1; step();
        idle(); lk_pc = 10'h103; #1;
        chk("flush_miss0", hit_o[0], 0); chk("flush_miss1", hit_o[1], 0);
        step();
        chk("flush_keeps_stats", sl0, 20);

        // Enable low: no allocation, stats hold
        idle(); en = 0; lk_valid = 1; upd_en = 1; upd_pc = 10'h055; upd_taken = 1; upd_target = 10'h155; step();
        idle(); lk_pc = 10'h055; #1;
        chk("en_low_no_alloc", hit_o[0], 0);
        chk("en_low_stats", sl0, 20);
        step();

        // Randomized traffic against the model
        for (int c = 0; c < 600; c++) begin
            en          = ($urandom_range(0, 9) != 0);
            flush       = ($urandom_range(0, 39) == 0);
            stat_clr    = ($urandom_range(0, 59) == 0);
            lk_valid    = $urandom_range(0, 1);
            lk_pc       = 10'h100 + 10'($urandom_range(0, 15));
            upd_en      = $urandom_range(0, 1);
            upd_pc      = 10'h100 + 10'($urandom_range(0, 15));
            upd_taken   = ($urandom_range(0, 2) != 0);
            upd_target  = 10'($urandom);
            upd_mispred = $urandom_range(0, 1);
            step();
        end

        // Asynchronous mid-cycle reset
        idle(); upd_en = 1; upd_pc = 10'h104; upd_taken = 1; lk_pc = 10'h104;
        #3 rst_n = 0; mreset();
        #1;
        for (int d = 0; d < 3; d++) chk($sformatf("async_rst_hit%0d", d), hit_o[d], 0);
        chk("async_rst_npc", npc0, 10'h105);
        chk("async_rst_stats", sl0, 0);
        #2 rst_n = 1;
        idle(); step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
